// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX->MEM stage register with valid/ready handshake and 2-entry skid buffer
// Optional stall/flush counters are enabled by defining EX_MEM_STAT_EN.
module ex_mem_pipe #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter bit ZERO_SUPP = 1'b1,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              mem_write_in,
    input  logic              mem_read_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [REG_AW-1:0] rd_in,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_write_out,
    output logic              mem_read_out,
    output logic              mem_to_reg_out,
    output logic              reg_write_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] write_data_out,
    output logic [REG_AW-1:0] rd_out
`ifdef EX_MEM_STAT_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
`endif
);

    if (STAT_W < 1) begin : gBadStatW
        $error("STAT_W must be at least 1");
    end

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    typedef struct packed {
        logic              memWrite;
        logic              memRead;
        logic              memToReg;
        logic              regWrite;
        logic [DATA_W-1:0] aluResult;
        logic [DATA_W-1:0] writeData;
        logic [REG_AW-1:0] rd;
    } entry_t;

    state_t state, nextState;
    entry_t mainReg, skidReg, inEntry;
    logic   acc, drn;
    logic   loadMainIn, loadMainSkid, loadSkid;

    assign inEntry = '{memWrite: mem_write_in, memRead: mem_read_in, memToReg: mem_to_reg_in,
                       regWrite: reg_write_in, aluResult: alu_result_in,
                       writeData: write_data_in, rd: rd_in};

    // ex_ready depends only on registered state so MEM back-pressure never reaches EX combinationally.
    assign ex_ready  = rst_n & (state != FULL);
    assign mem_valid = (state != EMPTY);
    assign acc       = ex_valid & ex_ready;
    assign drn       = mem_valid & mem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    nextState  = ONE;
                    loadMainIn = 1'b1;
                end
            end
            ONE: begin
                if (acc && drn) begin
                    loadMainIn = 1'b1;
                end else if (acc) begin
                    nextState = FULL;
                    loadSkid  = 1'b1;
                end else if (drn) begin
                    nextState = EMPTY;
                end
            end
            FULL: begin
                if (drn) begin
                    nextState    = ONE;
                    loadMainSkid = 1'b1;
                end
            end
            default: nextState = EMPTY;
        endcase
        // A squash drops everything held and any same-cycle accept; a same-cycle drain already left.
        if (flush) begin
            nextState    = EMPTY;
            loadMainIn   = 1'b0;
            loadMainSkid = 1'b0;
            loadSkid     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mainReg <= '0;
            skidReg <= '0;
        end else begin
            if (loadMainIn) begin
                mainReg <= inEntry;
            end else if (loadMainSkid) begin
                mainReg <= skidReg;
            end
            if (loadSkid) begin
                skidReg <= inEntry;
            end
        end
    end

    assign mem_write_out  = mainReg.memWrite & mem_valid;
    assign mem_read_out   = mainReg.memRead & mem_valid;
    assign mem_to_reg_out = mainReg.memToReg & mem_valid;
    assign reg_write_out  = mainReg.regWrite & mem_valid & ~(ZERO_SUPP && (mainReg.rd == '0));
    assign alu_result_out = mainReg.aluResult;
    assign write_data_out = mainReg.writeData;
    assign rd_out         = mainReg.rd;

`ifdef EX_MEM_STAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mem_valid && !mem_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && (state != EMPTY) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - scoreboard bench for ex_mem_pipe (stat checks when EX_MEM_STAT_EN is defined)
module tb_ex_mem_pipe;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n, flush, ex_valid, ex_ready, mem_valid, mem_ready;
    logic          mem_write_in, mem_read_in, mem_to_reg_in, reg_write_in;
    logic [DW-1:0] alu_result_in, write_data_in, alu_result_out, write_data_out;
    logic [AW-1:0] rd_in, rd_out;
    logic          mem_write_out, mem_read_out, mem_to_reg_out, reg_write_out;

    always #5 clk = ~clk;

`ifdef EX_MEM_STAT_EN
    logic [15:0]   stall_cnt, flush_cnt;
    logic [1:0]    stallCnt2, flushCnt2;
    logic          exReady2, memValid2, mw2, mr2, m2r2, rw2;
    logic [DW-1:0] alu2, wd2;
    logic [AW-1:0] rd2;
`endif

    ex_mem_pipe #(.DATA_W(DW), .REG_AW(AW), .ZERO_SUPP(1'b1), .STAT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .mem_write_in(mem_write_in), .mem_read_in(mem_read_in), .mem_to_reg_in(mem_to_reg_in),
        .reg_write_in(reg_write_in), .alu_result_in(alu_result_in), .write_data_in(write_data_in),
        .rd_in(rd_in), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_write_out(mem_write_out), .mem_read_out(mem_read_out), .mem_to_reg_out(mem_to_reg_out),
        .reg_write_out(reg_write_out), .alu_result_out(alu_result_out),
        .write_data_out(write_data_out), .rd_out(rd_out)
`ifdef EX_MEM_STAT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

`ifdef EX_MEM_STAT_EN
    ex_mem_pipe #(.DATA_W(DW), .REG_AW(AW), .ZERO_SUPP(1'b1), .STAT_W(2)) dutSmall (
        .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_ready(exReady2),
        .mem_write_in(mem_write_in), .mem_read_in(mem_read_in), .mem_to_reg_in(mem_to_reg_in),
        .reg_write_in(reg_write_in), .alu_result_in(alu_result_in), .write_data_in(write_data_in),
        .rd_in(rd_in), .mem_valid(memValid2), .mem_ready(mem_ready),
        .mem_write_out(mw2), .mem_read_out(mr2), .mem_to_reg_out(m2r2),
        .reg_write_out(rw2), .alu_result_out(alu2), .write_data_out(wd2), .rd_out(rd2),
        .stall_cnt(stallCnt2), .flush_cnt(flushCnt2)
    );
`endif

    typedef struct packed {
        logic          mw, mr, m2r, rw;
        logic [DW-1:0] alu, wd;
        logic [AW-1:0] rd;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops on every MEM-side handshake, then applies squash/reset, then records new accepts.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            check("mem_valid_occupancy", mem_valid, q.size() != 0);
            check("ex_ready_occupancy", ex_ready, q.size() < 2);
            if (mem_valid && mem_ready && q.size() > 0) begin
                e = q.pop_front();
                check("out_alu_result", alu_result_out, e.alu);
                check("out_write_data", write_data_out, e.wd);
                check("out_rd", rd_out, e.rd);
                check("out_mem_write", mem_write_out, e.mw);
                check("out_mem_read", mem_read_out, e.mr);
                check("out_mem_to_reg", mem_to_reg_out, e.m2r);
                check("out_reg_write", reg_write_out, e.rw);
            end
            if (flush) begin
                q.delete();
            end else if (ex_valid && ex_ready) begin
                e.mw  = mem_write_in;
                e.mr  = mem_read_in;
                e.m2r = mem_to_reg_in;
                e.rw  = reg_write_in & (rd_in != '0);
                e.alu = alu_result_in;
                e.wd  = write_data_in;
                e.rd  = rd_in;
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mw, input logic mr, input logic m2r, input logic rw,
                         input logic [DW-1:0] alu, input logic [DW-1:0] wd, input logic [AW-1:0] rd);
        mem_write_in  = mw;
        mem_read_in   = mr;
        mem_to_reg_in = m2r;
        reg_write_in  = rw;
        alu_result_in = alu;
        write_data_in = wd;
        rd_in         = rd;
        ex_valid      = 1'b1;
    endtask

    task automatic waitAccept(input string name);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (ex_ready) break;
            n++;
            if (n > 20) begin
                check(name, ex_ready, 1);
                break;
            end
        end
        step();
    endtask

    task automatic send(input logic mw, input logic mr, input logic m2r, input logic rw,
                        input logic [DW-1:0] alu, input logic [DW-1:0] wd, input logic [AW-1:0] rd);
        drive(mw, mr, m2r, rw, alu, wd, rd);
        waitAccept("accept_timeout");
    endtask

    task automatic drain();
        ex_valid  = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) step();
        step();
        check("drain_empty", mem_valid, 0);
    endtask

    task automatic checkCleared(input string name);
        check({name, "_mem_valid"}, mem_valid, 0);
        check({name, "_ex_ready"}, ex_ready, 0);
        check({name, "_alu"}, alu_result_out, 0);
        check({name, "_wd"}, write_data_out, 0);
        check({name, "_rd"}, rd_out, 0);
        check({name, "_ctrl"}, {mem_write_out, mem_read_out, mem_to_reg_out, reg_write_out}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        ex_valid = 1'b0;

        // Reset held for two cycles
        step(); step();
        checkCleared("reset");
        rst_n = 1'b1;
        #1;
        check("reset_release_ex_ready", ex_ready, 1);

        // Streaming at full rate
        mem_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, DW'(i), DW'(i * 16), AW'(i));
            step();
            check("stream_lag_alu", alu_result_out, i);
            check("stream_ex_ready", ex_ready, 1);
        end
        drain();

        // Back-pressure: A, B fill the stage, C waits
        mem_ready = 1'b0;
        send(1'b0, 1'b1, 1'b1, 1'b1, 32'hA, 32'h0, 5'd1);
        send(1'b1, 1'b0, 1'b0, 1'b0, 32'hB, 32'hBB, 5'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hC, 32'hCC, 5'd3);
        step(); step();
        check("bp_full_ex_ready", ex_ready, 0);
        check("bp_hold_alu", alu_result_out, 32'hA);
        mem_ready = 1'b1;
        waitAccept("bp_accept_c");
        drain();

        // Flush of a full stage holding a store, with EX presenting
        mem_ready = 1'b0;
        send(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'hDEAD, 5'd0);
        send(1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 32'h0, 5'd7);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h108, 32'h0, 5'd8);
        flush = 1'b1;
        step();
        flush = 1'b0; ex_valid = 1'b0;
        check("flush_full_mem_valid", mem_valid, 0);
        check("flush_full_mem_write", mem_write_out, 0);
        check("flush_data_kept", alu_result_out, 32'h100);
        mem_ready = 1'b1;
        step(); step();
        check("flush_full_nothing_out", mem_valid, 0);

        // Flush in ONE discards a same-cycle accept
        mem_ready = 1'b0;
        send(1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 5'd9);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h204, 32'h0, 5'd10);
        flush = 1'b1;
        step();
        flush = 1'b0; ex_valid = 1'b0;
        check("flush_one_mem_valid", mem_valid, 0);
        check("flush_one_ex_ready", ex_ready, 1);
        drain();

        // Zero-register suppression
        mem_ready = 1'b1;
        send(1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 5'd0);
        check("zero_rd_reg_write", reg_write_out, 0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 32'h66, 32'h0, 5'd5);
        check("rd5_reg_write", reg_write_out, 1);
        drain();

        // Reset mid-transfer from FULL
        mem_ready = 1'b0;
        send(1'b1, 1'b0, 1'b0, 1'b1, 32'h77, 32'h99, 5'd4);
        send(1'b0, 1'b1, 1'b1, 1'b1, 32'h78, 32'h0, 5'd6);
        ex_valid = 1'b0;
        rst_n = 1'b0;
        step();
        checkCleared("midreset");
        rst_n = 1'b1;
        #1;
        check("midreset_release_ex_ready", ex_ready, 1);

`ifdef EX_MEM_STAT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mem_ready = 1'b0;
        send(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 5'd1);
        ex_valid = 1'b0;
        step(); step(); step();
        check("stat_stall3", stall_cnt, 3);
        check("stat_flush0", flush_cnt, 0);
        flush = 1'b1; mem_ready = 1'b1;
        step();
        flush = 1'b0; mem_ready = 1'b0;
        check("stat_flush1", flush_cnt, 1);
        check("stat_stall_after_flush", stall_cnt, 3);
        check("stat_small_flush1", flushCnt2, 1);
        send(1'b0, 1'b1, 1'b0, 1'b1, 32'h304, 32'h0, 5'd2);
        ex_valid = 1'b0;
        step(); step();
        check("stat_stall5", stall_cnt, 5);
        check("stat_small_saturate", stallCnt2, 3);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
